// File: rtl/sram_arbiter.sv
// SRAM port arbiter: data beats fetch, holds the op until success,
// inserts a release cycle, places store lanes and aborts hung accesses.
module sram_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_ready_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_op_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [3:0]  ramOp_o,
  output logic [19:0] ramAddr_o,
  output logic [31:0] storeData_o,
  input  logic [31:0] loadData_i,
  input  logic        success_i
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DATA_BUSY = 2'd1;
  localparam logic [1:0] INST_BUSY = 2'd2;
  localparam logic [1:0] RELEASE   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             data_go;
  logic             inst_go;
  logic             data_ok;
  logic             timed_out;
  logic             unused_ok;

  function automatic logic op_valid(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU,
                      MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [31:0] place(
    input logic [3:0]  op,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = '0;
    unique case (1'b1)
      (op == MEM_SB): r = {wd[7:0], 24'b0};
      (op == MEM_SH): r = {wd[15:0], 16'b0};
      (op == MEM_SW): r = wd;
      default:        r = '0;
    endcase
    return r;
  endfunction

  // A ready pulse already in flight must not re-grant the same request.
  assign data_go   = data_req_i & ~data_ready_o;
  assign inst_go   = inst_req_i & ~inst_ready_o;
  assign stall_o   = data_go | inst_go;
  assign data_ok   = op_valid(data_op_i);
  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign unused_ok = ^{inst_addr_i[31:22], inst_addr_i[1:0],
                       data_addr_i[31:22], data_addr_i[1:0], MEM_NOP};

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ramOp_o      <= '0;
      ramAddr_o    <= '0;
      storeData_o  <= '0;
      inst_data_o  <= '0;
      data_rdata_o <= '0;
      inst_ready_o <= 1'b0;
      data_ready_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      inst_ready_o <= 1'b0;
      data_ready_o <= 1'b0;
      err_o        <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (data_go && data_ok) begin
            state       <= DATA_BUSY;
            ramOp_o     <= data_op_i;
            ramAddr_o   <= data_addr_i[21:2];
            storeData_o <= place(data_op_i, data_wdata_i);
          end else if (data_go) begin
            data_ready_o <= 1'b1;
            data_rdata_o <= '0;
          end else if (inst_go) begin
            state       <= INST_BUSY;
            ramOp_o     <= MEM_LW;
            ramAddr_o   <= inst_addr_i[21:2];
            storeData_o <= '0;
          end
        end
        DATA_BUSY, INST_BUSY: begin
          if (success_i) begin
            state   <= RELEASE;
            ramOp_o <= '0;
            cnt     <= '0;
            if (state == INST_BUSY) begin
              inst_ready_o <= 1'b1;
              inst_data_o  <= loadData_i;
            end else begin
              data_ready_o <= 1'b1;
              if (!is_store(ramOp_o)) data_rdata_o <= loadData_i;
            end
          end else if (timed_out) begin
            state   <= RELEASE;
            ramOp_o <= '0;
            cnt     <= '0;
            err_o   <= 1'b1;
            if (state == INST_BUSY) begin
              inst_ready_o <= 1'b1;
              inst_data_o  <= '0;
            end else begin
              data_ready_o <= 1'b1;
              data_rdata_o <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ramOp_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM controller model
// answering loads on the 3rd busy cycle and stores on the 5th.
module tb_sram_arbiter;

  localparam logic [3:0] MEM_LW = 4'd3;
  localparam logic [3:0] MEM_SB = 4'd6;
  localparam logic [3:0] MEM_SH = 4'd7;
  localparam logic [3:0] MEM_SW = 4'd8;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_ready_o;
  logic        data_req_i;
  logic [3:0]  data_op_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_ready_o;
  logic        err_o;
  logic        stall_o;
  logic [3:0]  ramOp_o;
  logic [19:0] ramAddr_o;
  logic [31:0] storeData_o;
  logic [31:0] loadData_i;
  logic        success_i;

  int checks = 0;
  int failures = 0;

  logic        sram_dead;
  logic [31:0] lddata;
  int          mcnt;

  logic [3:0]  op1;
  logic [19:0] addr1;
  logic [31:0] sd1;
  bit          stall_gap;
  bit          other_rdy;
  int          n;

  always #10 clk50 = ~clk50;

  sram_arbiter dut (
    .clk50        (clk50),
    .rst          (rst),
    .inst_req_i   (inst_req_i),
    .inst_addr_i  (inst_addr_i),
    .inst_data_o  (inst_data_o),
    .inst_ready_o (inst_ready_o),
    .data_req_i   (data_req_i),
    .data_op_i    (data_op_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_ready_o (data_ready_o),
    .err_o        (err_o),
    .stall_o      (stall_o),
    .ramOp_o      (ramOp_o),
    .ramAddr_o    (ramAddr_o),
    .storeData_o  (storeData_o),
    .loadData_i   (loadData_i),
    .success_i    (success_i)
  );

  // controller model: counts cycles the op has been presented
  always @(posedge clk50) begin
    if (ramOp_o == 4'd0) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always_comb begin
    success_i = 1'b0;
    if (!sram_dead && ramOp_o != 4'd0) begin
      if (ramOp_o inside {MEM_SB, MEM_SH, MEM_SW}) success_i = (mcnt == 4);
      else success_i = (mcnt == 2);
    end
  end

  assign loadData_i = success_i ? lddata : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input bit want_inst, output int cnt);
    cnt = 0;
    stall_gap = 0;
    other_rdy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk50);
      @(negedge clk50);
      if (i == 1) begin
        op1   = ramOp_o;
        addr1 = ramAddr_o;
        sd1   = storeData_o;
      end
      if (want_inst ? data_ready_o : inst_ready_o) other_rdy = 1;
      if (want_inst ? inst_ready_o : data_ready_o) begin
        cnt = i;
        break;
      end
      if (!stall_o) stall_gap = 1;
    end
  endtask

  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk50);
      @(negedge clk50);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req_i = 0;
    inst_addr_i = 0;
    data_req_i = 0;
    data_op_i = 0;
    data_addr_i = 0;
    data_wdata_i = 0;
    sram_dead = 0;
    lddata = 0;
    mcnt = 0;
    @(negedge clk50);
    chk("rst_ramop", ramOp_o, 0);
    chk("rst_rdata", data_rdata_o, 0);
    chk("rst_idata", inst_data_o, 0);
    chk("rst_rdy", {inst_ready_o, data_ready_o, err_o, stall_o}, 0);
    rst = 1'b0;
    gap(1);

    // data LW and fetch together: data first
    data_req_i = 1;
    data_op_i = MEM_LW;
    data_addr_i = 32'h0000_0010;
    inst_req_i = 1;
    inst_addr_i = 32'h0000_0400;
    lddata = 32'hDEAD_BEEF;
    #1 chk("prio_stall", stall_o, 1);
    wait_rdy(0, n);
    chk("prio_op", op1, MEM_LW);
    chk("prio_addr", addr1, 20'h00004);
    chk("prio_lat", n, 4);
    chk("prio_rdata", data_rdata_o, 32'hDEAD_BEEF);
    chk("prio_noinst", {other_rdy, inst_ready_o}, 0);
    data_req_i = 0;
    lddata = 32'h1111_2222;
    wait_rdy(1, n);
    chk("inst2_release_op", op1, 0);
    chk("inst2_lat", n, 5);
    chk("inst2_data", inst_data_o, 32'h1111_2222);
    inst_req_i = 0;
    gap(2);

    // fetch only
    inst_req_i = 1;
    inst_addr_i = 32'h0000_0400;
    lddata = 32'hCAFE_F00D;
    wait_rdy(1, n);
    chk("fetch_op", op1, MEM_LW);
    chk("fetch_addr", addr1, 20'h00100);
    chk("fetch_lat", n, 4);
    chk("fetch_data", inst_data_o, 32'hCAFE_F00D);
    chk("fetch_stall_busy", stall_gap, 0);
    chk("fetch_stall_rdy", stall_o, 0);
    gap(1);
    inst_req_i = 0;
    chk("fetch_pulse", inst_ready_o, 0);
    gap(2);

    // byte store
    data_req_i = 1;
    data_op_i = MEM_SB;
    data_addr_i = 32'h0000_0020;
    data_wdata_i = 32'h0000_00A5;
    lddata = 32'h5555_5555;
    wait_rdy(0, n);
    chk("sb_op", op1, MEM_SB);
    chk("sb_lanes", sd1, 32'hA500_0000);
    chk("sb_lat", n, 6);
    chk("sb_rdata_kept", data_rdata_o, 32'hDEAD_BEEF);
    chk("sb_release_op", ramOp_o, 0);
    data_req_i = 0;
    gap(2);

    // half store
    data_req_i = 1;
    data_op_i = MEM_SH;
    data_addr_i = 32'h0000_0024;
    data_wdata_i = 32'h0000_1234;
    wait_rdy(0, n);
    chk("sh_lanes", sd1, 32'h1234_0000);
    chk("sh_addr", addr1, 20'h00009);
    chk("sh_lat", n, 6);
    chk("sh_release_op", ramOp_o, 0);
    data_req_i = 0;
    gap(2);

    // controller never answers
    sram_dead = 1;
    data_req_i = 1;
    data_op_i = MEM_LW;
    data_addr_i = 32'h0000_0030;
    wait_rdy(0, n);
    chk("to_lat", n, 17);
    chk("to_err", err_o, 1);
    chk("to_rdata", data_rdata_o, 0);
    chk("to_op", ramOp_o, 0);
    data_req_i = 0;
    sram_dead = 0;
    gap(1);
    chk("to_err_pulse", err_o, 0);
    gap(1);
    data_req_i = 1;
    lddata = 32'h0BAD_F00D;
    wait_rdy(0, n);
    chk("after_to_lat", n, 4);
    chk("after_to_rdata", data_rdata_o, 32'h0BAD_F00D);
    chk("after_to_err", err_o, 0);
    data_req_i = 0;
    gap(2);

    // invalid op 0
    data_req_i = 1;
    data_op_i = 4'd0;
    wait_rdy(0, n);
    chk("inv_lat", n, 1);
    chk("inv_op", op1, 0);
    chk("inv_rdata", data_rdata_o, 0);
    chk("inv_err", err_o, 0);
    gap(1);
    chk("inv_single", {data_ready_o, ramOp_o}, 0);
    data_req_i = 0;
    gap(2);

    // reset in the middle of a word store
    data_req_i = 1;
    data_op_i = MEM_SW;
    data_addr_i = 32'h0000_0040;
    data_wdata_i = 32'h89AB_CDEF;
    gap(3);
    chk("sw_busy_op", ramOp_o, MEM_SW);
    chk("sw_busy_sd", storeData_o, 32'h89AB_CDEF);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_op", ramOp_o, 0);
    chk("rst_mid_sd", storeData_o, 0);
    chk("rst_mid_outs", {inst_data_o, data_rdata_o}, 0);
    data_req_i = 0;
    gap(1);
    rst = 1'b0;
    wait_rdy(0, n);
    chk("rst_no_ready", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sits directly upstream of the SRAM controller; the only block that drives its ramOp/ramAddr/storeData inputs.
- Arbitrates between the instruction-fetch port and the MEM-stage data port.
- Holds the granted operation stable until the controller reports success, then forces one idle cycle so the controller returns to IDLE.
- Performs store byte-lane placement, registers results back to the requesters, generates the pipeline stall, and aborts hung accesses by timeout.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles allowed without success_i before abort.
- CNT_W, 5: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk50  in  1  system clock
- rst  in  1  reset
- inst_req_i  in  1  fetch request; held until inst_ready_o
- inst_addr_i  in  32  fetch byte address
- inst_data_o  out  32  fetched word; registered
- inst_ready_o  out  1  one-cycle completion pulse
- data_req_i  in  1  data request; held until data_ready_o
- data_op_i  in  4  MEM_* code from defines.v
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  store data, right-aligned
- data_rdata_o  out  32  load result; registered
- data_ready_o  out  1  one-cycle completion pulse
- err_o  out  1  pulses with ready when the access timed out
- stall_o  out  1  pipeline stall
- ramOp_o  out  4  op to SRAM controller
- ramAddr_o  out  20  word address to SRAM controller
- storeData_o  out  32  lane-placed store data
- loadData_i  in  32  controller load result; valid while success_i=1
- success_i  in  1  controller completion, combinational

Behaviour:
- Reset is asynchronous and active-high, on rst; clock is clk50.
- Reset values: state=IDLE; ramOp_o=0, ramAddr_o=0, storeData_o=0, inst_data_o=0, data_rdata_o=0, inst_ready_o=0, data_ready_o=0, err_o=0; timeout counter=0.
- All ram-side outputs and all requester outputs are registered.
- stall_o is combinational: (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o).
- States: IDLE, DATA_BUSY, INST_BUSY, RELEASE.
- IDLE:
  - data_req_i=1 with a valid op (LW/LB/LBU/LH/LHU/SW/SB/SH) -> latch the request, go to DATA_BUSY.
  - Otherwise inst_req_i=1 -> latch with op=MEM_LW, go to INST_BUSY.
  - data_req_i=1 with an invalid op (including 0) -> no SRAM access; data_ready_o pulses next cycle with data_rdata_o=0 and err_o=0; stay in IDLE.
  - Fixed priority: data beats inst when both requests are asserted.
- BUSY (ram-side outputs held constant for the whole state):
  - ramOp_o = latched op.
  - ramAddr_o = addr[21:2].
  - storeData_o lane placement:
    - SB -> {wdata[7:0], 24'b0}
    - SH -> {wdata[15:0], 16'b0}
    - SW -> wdata
    - loads -> 0
  - Counter increments each BUSY cycle.
- Completion:
  - Condition: success_i=1 sampled at an edge in BUSY.
  - Actions at that edge:
    - Capture loadData_i into inst_data_o or data_rdata_o; stores leave data_rdata_o unchanged.
    - Pulse the matching ready for one cycle.
    - Drive ramOp_o=0.
    - Enter RELEASE.
- RELEASE:
  - Lasts exactly one cycle with ramOp_o=0, then IDLE.
  - A new grant is evaluated in IDLE, so back-to-back accesses are separated by RELEASE and IDLE.
- Latency, in edges from the edge that samples the request to ready high:
  - Loads/fetch: 4.
  - Stores: 6.
- Timeout:
  - Trigger: counter reaches TIMEOUT_CYCLES in BUSY without success_i.
  - Actions: ramOp_o=0; matching ready pulse with err_o=1; that port's data output set to 0; enter RELEASE; counter cleared.
- Request withdrawn mid-access: the access completes normally and the ready pulse is still issued; the requester ignores it.
- rst mid-access: immediate return to IDLE with ramOp_o=0; the controller aborts because it sees op 0.
- Requests are sampled only in IDLE. Address/op changes during BUSY are ignored; latched values are used.

Test Plan:
- Data load priority: data_req LW at addr 0x0000_0010 together with inst_req -> ramAddr_o=0x00004, ramOp_o=MEM_LW; model returns 0xDEADBEEF with success -> data_rdata_o=0xDEADBEEF and data_ready_o 4 edges after the request; inst is served afterwards, no overlap.
- SB of 0x000000A5 -> storeData_o=0xA5000000; SH of 0x00001234 -> storeData_o=0x12340000; each data_ready_o at 6 edges; ramOp_o=0 for exactly one cycle between them.
- Fetch only at 0x0000_0400 -> ramAddr_o=0x00100, op MEM_LW, inst_data_o captured, inst_ready_o 1-cycle pulse; stall_o=1 throughout and 0 in the ready cycle.
- success_i held 0 -> after 16 BUSY cycles: ramOp_o=0, data_ready_o=1 and err_o=1 together, data_rdata_o=0; next request proceeds normally.
- data_op_i=0 with data_req_i=1 -> no ramOp_o activity, data_ready_o next cycle, err_o=0.
- rst asserted during a store's WRITE2 window -> ramOp_o=0 and all outputs at reset values immediately; no ready pulse.
